regfile: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file: the write-back endpoint of the pipeline.
- Consumes the registered WB write (waddr/we/wdata) from the MEM/WB stage.
- Serves two combinational read ports to the ID stage.
- $0 is hardwired to zero; a same-cycle WB-to-ID write-through bypass removes the structural hazard between WB and ID.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile.sv | 101 ++++++++++
 tb/tb_regfile.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS general-purpose register file.
// Control-level encodings, the zero word and the register-array geometry.
package regfile_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic RESETABLE   = 1'b1;
  localparam logic WRITEABLE   = 1'b1;
  localparam logic UNWRITEABLE = 1'b0;
  localparam logic READABLE    = 1'b1;
  localparam logic UNREADABLE  = 1'b0;

  localparam logic [RegBus-1:0]     ZEROWORD   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: one WB write port, two combinational ID read ports.
// Define REGFILE_BYPASS_EN to forward the WB write data to a same-cycle read of that register.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam logic [DATA_W-1:0] ZERO_W = DATA_W'(ZEROWORD);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(NOPRegAddr);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              wr_en;
  logic              hit1;
  logic              hit2;

  // Index 0 is never written, so $0 stays at the value reset gave it.
  assign wr_en = (we != UNWRITEABLE) && (waddr != ZERO_A);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (rst == RESETABLE) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_d[i] = ZERO_W;
      end
    end else if (wr_en) begin
      mem_d[waddr] = wdata;
    end
  end

  // NOTE: the whole array is reset here because the pipeline relies on every
  // register reading zero after reset; non-blocking assignments keep all
  // entries updating together at the edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    hit1 = (rst != RESETABLE) && (we == WRITEABLE) && (waddr == raddr1) &&
           (raddr1 != ZERO_A) && (re1 == READABLE);
    hit2 = (rst != RESETABLE) && (we == WRITEABLE) && (waddr == raddr2) &&
           (raddr2 != ZERO_A) && (re2 == READABLE);
  end
`else
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
  end
`endif

  // Per-port read priority: reset, $0, bypass, enabled array read, disabled.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst_i,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              hit,
    input logic [DATA_W-1:0] fwd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] word;
    word = ZERO_W;
    if (rst_i == RESETABLE) begin
      word = ZERO_W;
    end else if (raddr == ZERO_A) begin
      word = ZERO_W;
    end else if (hit) begin
      word = fwd;
    end else if (re == UNREADABLE) begin
      word = ZERO_W;
    end else begin
      word = stored;
    end
    return word;
  endfunction

  always_comb begin
    rdata1 = read_mux(rst, re1, raddr1, hit1, wdata, mem_q[raddr1]);
    rdata2 = read_mux(rst, re2, raddr2, hit2, wdata, mem_q[raddr2]);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array model of the architectural register state.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int vectors;
  int miscompares;

  logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the architectural rules and the current inputs.
  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
    if (rst) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (BYPASS && we && waddr == ra && re) return wdata;
    if (re) return model[ra];
    return 32'h0;
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL reset_rd1: got %h expected %h", rdata1, 32'h0); end
    vectors++;
    if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL reset_rd2: got %h expected %h", rdata2, 32'h0); end
    tick();
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b0; re2 = 1'b0;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL r5_before_reset: got %h expected %h", rdata1, 32'hDEADBEEF); end
    tick();
    rst = 1'b1; re2 = 1'b1; raddr2 = 5'd5;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL rd1_during_rst: got %h expected %h", rdata1, 32'h0); end
    vectors++;
    if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL rd2_during_rst: got %h expected %h", rdata2, 32'h0); end
    tick();
    rst = 1'b0; re2 = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL r5_after_reset: got %h expected %h", rdata1, 32'h0); end
    idle_inputs();
  endtask

  task automatic test_zero_immunity();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1'b1; raddr1 = 5'd0;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL r0_same_cycle: got %h expected %h", rdata1, 32'h0); end
    tick();
    we = 1'b0; re2 = 1'b1; raddr2 = 5'd0;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL r0_next_cycle_rd1: got %h expected %h", rdata1, 32'h0); end
    vectors++;
    if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL r0_next_cycle_rd2: got %h expected %h", rdata2, 32'h0); end
    idle_inputs();
  endtask

  task automatic test_basic();
    we = 1'b1; waddr = 5'd31; wdata = 32'h12345678;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd31;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'h12345678) begin miscompares++; $display("FAIL r31_rd1: got %h expected %h", rdata1, 32'h12345678); end
    vectors++;
    if (rdata2 !== 32'h12345678) begin miscompares++; $display("FAIL r31_rd2: got %h expected %h", rdata2, 32'h12345678); end
    re2 = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL r31_rd2_disabled: got %h expected %h", rdata2, 32'h0); end
    idle_inputs();
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp_now;
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    tick();
    wdata = 32'hA5A5A5A5; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
    exp_now = BYPASS ? 32'hA5A5A5A5 : 32'h11111111;
    @(negedge clk);
    vectors++;
    if (rdata1 !== exp_now) begin miscompares++; $display("FAIL rdw_same_cycle: got %h expected %h", rdata1, exp_now); end
    vectors++;
    if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL rdw_disabled_port: got %h expected %h", rdata2, 32'h0); end
    tick();
    we = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL rdw_next_cycle: got %h expected %h", rdata1, 32'hA5A5A5A5); end
    idle_inputs();
  endtask

  task automatic test_reset_during_write();
    we = 1'b1; waddr = 5'd3; wdata = 32'h77;
    tick();
    rst = 1'b1; wdata = 32'h55;
    tick();
    rst = 1'b0; we = 1'b0; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd31;
    @(negedge clk);
    vectors++;
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL r3_after_rst_write: got %h expected %h", rdata1, 32'h0); end
    vectors++;
    if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL r31_after_rst_write: got %h expected %h", rdata2, 32'h0); end
    idle_inputs();
  endtask

  task automatic test_sweep();
    logic [31:0] exp_v;
    logic [31:0] got;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      re1 = 1'b0; re2 = 1'b0;
      if (i % 2 == 0) begin re1 = 1'b1; raddr1 = 5'(i); end
      else            begin re2 = 1'b1; raddr2 = 5'(i); end
      exp_v = 32'(i) * 32'h01010101;
      @(negedge clk);
      got = (i % 2 == 0) ? rdata1 : rdata2;
      vectors++;
      if (got !== exp_v) begin miscompares++; $display("FAIL sweep_r%0d: got %h expected %h", i, got, exp_v); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] e1;
    logic [31:0] e2;
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 31) == 0);
      we     = $urandom_range(0, 1) == 1;
      waddr  = 5'($urandom);
      wdata  = $urandom;
      re1    = $urandom_range(0, 3) != 0;
      re2    = $urandom_range(0, 3) != 0;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      e1 = exp_read(re1, raddr1);
      e2 = exp_read(re2, raddr2);
      @(negedge clk);
      vectors++;
      if (rdata1 !== e1) begin miscompares++; $display("FAIL random_rd1 #%0d a=%0d: got %h expected %h", n, raddr1, rdata1, e1); end
      vectors++;
      if (rdata2 !== e2) begin miscompares++; $display("FAIL random_rd2 #%0d a=%0d: got %h expected %h", n, raddr2, rdata2, e2); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    idle_inputs();
    test_reset();
    test_zero_immunity();
    test_basic();
    test_read_during_write();
    test_reset_during_write();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
